// File: rtl/rdesp_sequencer.sv
// rdesp_sequencer: command-driven controller for a 4-bit shift register.
// One command is taken per valid/ready handshake. The sequencer then walks
// the register through an optional parallel load followed by N shift/rotate
// steps. It then samples the register output and pulses done for one cycle.
// Register-control outputs decode from the state and the latched command
// fields only, so a changing cmd_* bus can never disturb an operation in flight.
module rdesp_sequencer #(
  parameter int CW = 4,  // width of the step-count field
  parameter int W  = 4   // register data width
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic          cmd_dir,
  input  logic          cmd_sin,
  input  logic [CW-1:0] cmd_count,
  input  logic [W-1:0]  cmd_data,
  input  logic [W-1:0]  q_in,
  output logic          reg_enb,
  output logic [1:0]    reg_modo,
  output logic          reg_dir,
  output logic          reg_s_in,
  output logic [W-1:0]  reg_d,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  result
);

  // Sequencer states.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_CAPT = 2'd3;

  // Command opcodes.
  localparam logic [1:0] OP_SHIFT      = 2'b00;
  localparam logic [1:0] OP_ROTATE     = 2'b01;
  localparam logic [1:0] OP_LOAD       = 2'b10;
  localparam logic [1:0] OP_LOAD_SHIFT = 2'b11;

  // Register mode encodings.
  localparam logic [1:0] MODO_SERIAL = 2'b00;
  localparam logic [1:0] MODO_ROTATE = 2'b01;
  localparam logic [1:0] MODO_LOAD   = 2'b10;

  localparam logic [CW-1:0] CNT_ZERO = '0;
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  logic [1:0]    state_reg;
  logic [1:0]    state_next;
  logic [CW-1:0] remain_reg;
  logic [CW-1:0] remain_next;

  // Latched command fields; only these steer the register during an operation.
  logic [1:0]    op_reg;
  logic          dir_reg;
  logic          sin_reg;
  logic [CW-1:0] count_reg;
  logic [W-1:0]  data_reg;

  logic          done_reg;
  logic [W-1:0]  result_reg;

  logic          accept;
  logic          load_phase;
  logic          run_phase;
  logic          rotate_op;

  // Ready only in IDLE. It is also held low for as long as reset is asserted.
  assign cmd_ready = rst_n & (state_reg == ST_IDLE);
  assign accept    = cmd_valid & cmd_ready;
  assign busy      = (state_reg != ST_IDLE);
  assign done      = done_reg;
  assign result    = result_reg;

  assign load_phase = (state_reg == ST_LOAD);
  assign run_phase  = (state_reg == ST_RUN);
  assign rotate_op  = (op_reg == OP_ROTATE);

  // Next-state and step-counter logic. RUN lasts exactly count cycles:
  // it is entered with remain=count and left on the cycle remain reaches 1.
  always_comb begin
    state_next  = state_reg;
    remain_next = remain_reg;
    unique case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          if (cmd_op == OP_LOAD || cmd_op == OP_LOAD_SHIFT) begin
            state_next = ST_LOAD;
          end else if (cmd_count != CNT_ZERO) begin
            state_next  = ST_RUN;
            remain_next = cmd_count;
          end else begin
            state_next = ST_CAPT;
          end
        end
      end
      ST_LOAD: begin
        if (op_reg == OP_LOAD_SHIFT && count_reg != CNT_ZERO) begin
          state_next  = ST_RUN;
          remain_next = count_reg;
        end else begin
          state_next = ST_CAPT;
        end
      end
      ST_RUN: begin
        remain_next = remain_reg - CNT_ONE;
        // "<=" rather than "==" so a corrupted zero count cannot wrap to 2^CW-1.
        if (remain_reg <= CNT_ONE) begin
          state_next = ST_CAPT;
        end
      end
      ST_CAPT: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next  = ST_IDLE;
        remain_next = CNT_ZERO;
      end
    endcase
  end

  // State and step counter. An asynchronous reset abandons any command in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      remain_reg <= CNT_ZERO;
    end else begin
      state_reg  <= state_next;
      remain_reg <= remain_next;
    end
  end

  // Capture the command fields on the handshake edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_reg    <= OP_SHIFT;
      dir_reg   <= 1'b0;
      sin_reg   <= 1'b0;
      count_reg <= CNT_ZERO;
      data_reg  <= '0;
    end else if (accept) begin
      op_reg    <= cmd_op;
      dir_reg   <= cmd_dir;
      sin_reg   <= cmd_sin;
      count_reg <= cmd_count;
      data_reg  <= cmd_data;
    end
  end

  // Completion: sample q on the edge that leaves CAPT and pulse done once.
  // The register is disabled throughout CAPT, so q_in is stable here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_reg   <= 1'b0;
      result_reg <= '0;
    end else begin
      done_reg <= (state_reg == ST_CAPT);
      if (state_reg == ST_CAPT) begin
        result_reg <= q_in;
      end
    end
  end

  // Register control. This decode is purely combinational from the state flops.
  // An asynchronous reset therefore drops reg_enb at once, not on the next edge.
  assign reg_enb  = load_phase | run_phase;
  assign reg_modo = load_phase               ? MODO_LOAD   :
                    (run_phase && rotate_op) ? MODO_ROTATE : MODO_SERIAL;
  assign reg_dir  = run_phase & dir_reg;
  // The serial input matters only for shift steps. It is zero while rotating.
  assign reg_s_in = run_phase & ~rotate_op & sin_reg;

  // The parallel word is presented only during the load cycle. It is zero otherwise.
  generate
    for (genvar gi = 0; gi < W; gi++) begin : g_reg_d
      assign reg_d[gi] = load_phase & data_reg[gi];
    end
  endgenerate

endmodule

// File: tb/tb_rdesp_sequencer.sv
// Testbench for rdesp_sequencer. A behavioural 4-bit shift register closes
// the loop on q_in. Every command's result, latency and number of register
// enable cycles are predicted by a word-level arithmetic model of the commands.
module tb_rdesp_sequencer;

  localparam int CW = 4;
  localparam int W  = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic          cmd_dir;
  logic          cmd_sin;
  logic [CW-1:0] cmd_count;
  logic [W-1:0]  cmd_data;
  logic [W-1:0]  q_in;
  logic          reg_enb;
  logic [1:0]    reg_modo;
  logic          reg_dir;
  logic          reg_s_in;
  logic [W-1:0]  reg_d;
  logic          busy;
  logic          done;
  logic [W-1:0]  result;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [1:0] op;
    logic       dir;
    logic       sin;
    logic [3:0] count;
    logic [3:0] data;
  } cmd_t;

  logic [3:0] model_q = 4'd0;
  logic [3:0] q_reg   = 4'd0;

  always #5 clk = ~clk;

  rdesp_sequencer #(.CW(CW), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_dir   (cmd_dir),
    .cmd_sin   (cmd_sin),
    .cmd_count (cmd_count),
    .cmd_data  (cmd_data),
    .q_in      (q_in),
    .reg_enb   (reg_enb),
    .reg_modo  (reg_modo),
    .reg_dir   (reg_dir),
    .reg_s_in  (reg_s_in),
    .reg_d     (reg_d),
    .busy      (busy),
    .done      (done),
    .result    (result)
  );

  // The external shift register driven by the sequencer. It is not reset.
  always @(posedge clk) begin
    if (reg_enb) begin
      case (reg_modo)
        2'b00:   q_reg <= reg_dir ? {reg_s_in, q_reg[3:1]} : {q_reg[2:0], reg_s_in};
        2'b01:   q_reg <= reg_dir ? {q_reg[0], q_reg[3:1]} : {q_reg[2:0], q_reg[3]};
        2'b10:   q_reg <= reg_d;
        default: q_reg <= q_reg;
      endcase
    end
  end
  assign q_in = q_reg;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic cmd_t mk(input int op, input int dir, input int sin, input int cnt, input int data);
    cmd_t c;
    c.op    = op[1:0];
    c.dir   = dir[0];
    c.sin   = sin[0];
    c.count = cnt[3:0];
    c.data  = data[3:0];
    return c;
  endfunction

  function automatic cmd_t rand_cmd();
    return mk($urandom % 4, $urandom % 2, $urandom % 2, $urandom % 16, $urandom % 16);
  endfunction

  // Word-level reference: load, then count steps of shift or rotate using
  // integer arithmetic on the 4-bit value.
  function automatic logic [3:0] ref_result(input cmd_t c, input logic [3:0] q);
    int v, s, n;
    v = int'(q);
    s = int'(c.sin);
    n = int'(c.count);
    if (c.op == 2'b10 || c.op == 2'b11) v = int'(c.data);
    if (c.op != 2'b10) begin
      for (int i = 0; i < n; i++) begin
        if (c.op == 2'b01)
          v = c.dir ? ((v / 2) + (v % 2) * 8) : (((v * 2) % 16) + (v / 8));
        else
          v = c.dir ? ((v / 2) + s * 8) : (((v * 2) % 16) + s);
      end
    end
    return v[3:0];
  endfunction

  function automatic int ref_latency(input cmd_t c);
    case (c.op)
      2'b10:   return 2;
      2'b11:   return int'(c.count) + 2;
      default: return (c.count == 0) ? 1 : int'(c.count) + 1;
    endcase
  endfunction

  function automatic int ref_enb_cycles(input cmd_t c);
    int n;
    n = (c.op == 2'b10) ? 0 : int'(c.count);
    return n + ((c.op[1]) ? 1 : 0);
  endfunction

  task automatic drive(input cmd_t c, input logic v);
    cmd_op    = c.op;
    cmd_dir   = c.dir;
    cmd_sin   = c.sin;
    cmd_count = c.count;
    cmd_data  = c.data;
    cmd_valid = v;
  endtask

  // Runs command c, which is already on the bus with cmd_valid=1. The task is
  // called at a negedge. If has_next is set, nxt is driven right after the
  // acceptance edge, so that nxt is accepted in the cycle where done=1.
  task automatic execute(input cmd_t c, input bit has_next, input cmd_t nxt);
    int wait_cyc = 0;
    int cyc = 0;
    int enb_cnt = 0;
    int load_cnt = 0;
    int ready_busy = 0;
    logic [3:0] exp_res;
    while (!cmd_ready && wait_cyc < 50) begin
      @(negedge clk);
      wait_cyc++;
    end
    check_eq("accept_wait", (wait_cyc < 50), 1);
    exp_res = ref_result(c, model_q);
    model_q = exp_res;
    @(posedge clk);
    #1;
    if (has_next) drive(nxt, 1'b1);
    else cmd_valid = 1'b0;
    do begin
      @(negedge clk);
      cyc++;
      if (reg_enb) enb_cnt++;
      if (reg_enb && reg_modo == 2'b10) load_cnt++;
      if (!done && (busy !== 1'b1 || cmd_ready !== 1'b0)) ready_busy++;
    end while (!done && cyc < 40);
    check_eq("latency", cyc - 1, ref_latency(c));
    check_eq("result", result, exp_res);
    check_eq("enb_cycles", enb_cnt, ref_enb_cycles(c));
    check_eq("load_cycles", load_cnt, c.op[1] ? 1 : 0);
    check_eq("ready_while_busy", ready_busy, 0);
    check_eq("busy_after", busy, 0);
    check_eq("ready_after", cmd_ready, 1);
    $display("cmd op=%0d dir=%0d sin=%0d cnt=%0d data=%b -> result=%b latency=%0d enb=%0d",
             c.op, c.dir, c.sin, c.count, c.data, result, cyc - 1, enb_cnt);
  endtask

  // Issues one command after the current negedge and runs it to completion.
  task automatic run_one(input cmd_t c);
    drive(c, 1'b1);
    execute(c, 1'b0, c);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    cmd_t c;
    cmd_t n;
    bit pending;
    bit chain;
    int done_seen;

    rst_n = 1'b0;
    drive(mk(0, 0, 0, 0, 0), 1'b0);
    #1;
    check_eq("rst_ready", cmd_ready, 0);
    check_eq("rst_enb", reg_enb, 0);
    check_eq("rst_modo", reg_modo, 0);
    check_eq("rst_d", reg_d, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_result", result, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("ready_after_rst", cmd_ready, 1);

    // Directed cases.
    run_one(mk(2, 0, 0, 0, 4'b1011));
    run_one(mk(2, 0, 0, 0, 4'b0111));
    run_one(mk(1, 0, 0, 1, 0));
    run_one(mk(1, 1, 0, 2, 0));
    run_one(mk(3, 0, 1, 2, 4'b0000));
    run_one(mk(0, 1, 0, 3, 0));
    run_one(mk(2, 0, 0, 0, 4'b0101));
    run_one(mk(0, 0, 1, 0, 0));
    run_one(mk(1, 1, 0, 15, 0));

    // Back-to-back: the second command waits on the bus while the first is busy.
    c = mk(1, 0, 0, 3, 0);
    n = mk(3, 1, 1, 2, 4'b1001);
    drive(c, 1'b1);
    execute(c, 1'b1, n);
    execute(n, 1'b0, n);

    // Randomized commands, some chained back-to-back.
    pending = 1'b0;
    for (int i = 0; i < 120; i++) begin
      if (!pending) begin
        repeat ($urandom % 3) @(negedge clk);
        c = rand_cmd();
        drive(c, 1'b1);
      end
      chain = ($urandom % 3 == 0);
      n = rand_cmd();
      execute(c, chain, n);
      if (chain) begin
        c = n;
        pending = 1'b1;
      end else begin
        pending = 1'b0;
      end
    end
    if (pending) execute(c, 1'b0, c);

    // Reset in the middle of a long rotate.
    run_one(mk(2, 0, 0, 0, 4'b1010));
    drive(mk(1, 0, 0, 10, 0), 1'b1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("mid_rotate_enb", reg_enb, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_enb_drop", reg_enb, 0);
    check_eq("async_busy", busy, 0);
    check_eq("async_ready", cmd_ready, 0);
    check_eq("async_result", result, 0);
    check_eq("async_done", done, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check_eq("no_done_after_rst", done_seen, 0);
    check_eq("ready_after_release", cmd_ready, 1);
    check_eq("result_held_zero", result, 0);
    $display("reset applied mid-rotate, command dropped");

    // Resynchronise the model with a load, then confirm normal operation.
    run_one(mk(2, 0, 0, 0, 4'b0110));
    run_one(mk(1, 0, 0, 5, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
